// File: rtl/sseg_pkg.sv
// Shared constants for the multiplexed seven-segment display path (driver and scan decoder).
// Cathode/anode encodings are active-low.
package sseg_pkg;

    typedef logic [3:0] bcd_t;

    // Cathode patterns {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    localparam logic [7:0] AN_DIG0 = 8'b11111110;
    localparam logic [7:0] AN_DIG1 = 8'b11111101;
    localparam logic [7:0] AN_DIG2 = 8'b11111011;
    localparam logic [7:0] AN_DIG3 = 8'b11110111;

    // d3*1000 + d2*100 + d1*10 + d0 using shifts and adds only
    function automatic logic [15:0] bcd_to_bin(input bcd_t d3, input bcd_t d2,
                                               input bcd_t d1, input bcd_t d0);
        logic [15:0] t3, t2, t1, t0;
        t3 = {12'd0, d3};
        t2 = {12'd0, d2};
        t1 = {12'd0, d1};
        t0 = {12'd0, d0};
        return (t3 << 9) + (t3 << 8) + (t3 << 7) + (t3 << 6) + (t3 << 5) + (t3 << 3)
             + (t2 << 6) + (t2 << 5) + (t2 << 2)
             + (t1 << 3) + (t1 << 1)
             + t0;
    endfunction

endpackage

// File: rtl/sseg_to_bcd.sv
// Combinational decode of one active-low cathode pattern back to a BCD digit.
// valid is low for any pattern outside the ten digit glyphs.
module sseg_to_bcd
    import sseg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] bcd,
    output logic       valid
);

    always_comb begin
        bcd   = 4'd0;
        valid = 1'b1;
        case (pattern)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Reads back the scanned 4-digit seven-segment bus, waits for each digit to settle,
// and rebuilds the displayed number as BCD digits and as a binary value.
module sseg_scan_decoder
    import sseg_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  an,
    input  logic [6:0]  sseg,
    output logic [15:0] digits,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        changed,
    output logic        stale
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES - 1);

    logic [14:0]   samp;
    logic [14:0]   samp_prev;
    logic [SW-1:0] settle_cnt;
    logic          captured;
    logic [3:0]    seen;
    logic [3:0]    bad;
    logic [3:0]    seen_nx;
    logic [3:0]    bad_nx;
    bcd_t [3:0]    shadow;
    logic [TW-1:0] idle_cnt;

    logic          stable;
    logic          an_ok;
    logic [1:0]    an_idx;
    logic          capture;
    logic          complete;
    bcd_t          dec_bcd;
    logic          dec_ok;
    logic [15:0]   shadow_bin;

    sseg_to_bcd u_to_bcd (
        .pattern (samp[6:0]),
        .bcd     (dec_bcd),
        .valid   (dec_ok)
    );

    // Only a single lit lower digit with the upper four anodes dark qualifies
    always_comb begin
        an_ok  = 1'b1;
        an_idx = 2'd0;
        case (samp[14:7])
            AN_DIG0: an_idx = 2'd0;
            AN_DIG1: an_idx = 2'd1;
            AN_DIG2: an_idx = 2'd2;
            AN_DIG3: an_idx = 2'd3;
            default: an_ok  = 1'b0;
        endcase
    end

    assign stable     = (samp == samp_prev);
    assign capture    = stable && (settle_cnt == SETTLE_MAX) && !captured && an_ok;
    assign complete   = (seen == 4'b1111);
    assign shadow_bin = bcd_to_bin(shadow[3], shadow[2], shadow[1], shadow[0]);

    // A capture landing on the completion cycle counts toward the next frame
    always_comb begin
        seen_nx = complete ? 4'b0000 : seen;
        bad_nx  = complete ? 4'b0000 : bad;
        if (capture) begin
            seen_nx[an_idx] = 1'b1;
            bad_nx[an_idx]  = ~dec_ok;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp       <= '0;
            samp_prev  <= '0;
            settle_cnt <= '0;
            captured   <= 1'b0;
        end else begin
            samp      <= {an, sseg};
            samp_prev <= samp;
            if (!stable) begin
                settle_cnt <= '0;
                captured   <= 1'b0;
            end else begin
                if (settle_cnt != SETTLE_MAX)
                    settle_cnt <= settle_cnt + 1'b1;
                if (capture)
                    captured <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seen        <= 4'b0000;
            bad         <= 4'b0000;
            shadow      <= '0;
            digits      <= 16'd0;
            value       <= 16'd0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            changed     <= 1'b0;
        end else begin
            seen        <= seen_nx;
            bad         <= bad_nx;
            frame_valid <= complete && (bad == 4'b0000);
            frame_err   <= complete && (bad != 4'b0000);
            changed     <= complete && (bad == 4'b0000) && (shadow_bin != value);
            if (capture && dec_ok)
                shadow[an_idx] <= dec_bcd;
            if (complete && (bad == 4'b0000)) begin
                digits <= shadow;
                value  <= shadow_bin;
            end
        end
    end

    // Watchdog on frame completions; saturates once stale
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
            stale    <= 1'b0;
        end else if (complete) begin
            idle_cnt <= '0;
            stale    <= 1'b0;
        end else if (idle_cnt == TIMEOUT_MAX) begin
            stale <= 1'b1;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Bench for sseg_scan_decoder: directed display scans plus random dwells, checked every
// cycle against a frame-level model of the display bus.
module tb_sseg_scan_decoder;

  localparam int S = 16;
  localparam int T = 3000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  an_in;
  logic [6:0]  sseg_in;
  logic [15:0] digits;
  logic [15:0] value;
  logic        frame_valid;
  logic        frame_err;
  logic        changed;
  logic        stale;

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  sseg_scan_decoder #(
    .SETTLE_CYCLES  (S),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .an          (an_in),
    .sseg        (sseg_in),
    .digits      (digits),
    .value       (value),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .changed     (changed),
    .stale       (stale)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at edge %0d", name, got, exp_v, edge_cnt);
    end
  endtask

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  function automatic int an_index(input logic [7:0] a);
    case (a)
      8'b11111110: return 0;
      8'b11111101: return 1;
      8'b11111011: return 2;
      8'b11110111: return 3;
      default:     return -1;
    endcase
  endfunction

  function automatic int seg_digit(input logic [6:0] s);
    for (int i = 0; i < 10; i++)
      if (s == seg_tab[i]) return i;
    return -1;
  endfunction

  // ---------------- reference model ----------------
  // A dwell held for at least S+1 sampling edges starting at edge n is captured at edge n+S+1.
  typedef struct {
    int         at_edge;
    logic [7:0] a;
    logic [6:0] s;
  } cap_t;

  cap_t        cap_q[$];
  logic [15:0] exp_q[$];
  logic [3:0]  m_seen;
  logic [3:0]  m_bad;
  int          m_sh [4];
  int          m_value;
  logic [15:0] m_digits;
  int          last_comp;
  int          n_fv = 0;
  int          n_fe = 0;
  int          n_ch = 0;

  always @(negedge clk) begin
    logic e_fv, e_fe, e_ch, e_stale;
    int   newv, idx, d;
    cap_t c;
    if (reset) begin
      m_seen = 4'b0; m_bad = 4'b0; m_value = 0; m_digits = 16'd0;
      for (int i = 0; i < 4; i++) m_sh[i] = 0;
      cap_q.delete();
      last_comp = edge_cnt + 1;
      check("reset_value", value, 0);
      check("reset_digits", digits, 0);
      check("reset_pulses", {frame_valid, frame_err, changed}, 0);
      check("reset_stale", stale, 0);
    end else begin
      e_fv = 1'b0; e_fe = 1'b0; e_ch = 1'b0;
      if (m_seen == 4'b1111) begin
        if (m_bad == 4'b0000) begin
          newv = m_sh[3] * 1000 + m_sh[2] * 100 + m_sh[1] * 10 + m_sh[0];
          e_fv = 1'b1;
          e_ch = (newv != m_value);
          m_value = newv;
          m_digits = 16'(m_sh[3] * 4096 + m_sh[2] * 256 + m_sh[1] * 16 + m_sh[0]);
          exp_q.push_back(16'(newv));
        end else begin
          e_fe = 1'b1;
        end
        m_seen = 4'b0;
        m_bad = 4'b0;
        last_comp = edge_cnt;
      end
      if (cap_q.size() > 0 && cap_q[0].at_edge == edge_cnt) begin
        c = cap_q.pop_front();
        idx = an_index(c.a);
        d = seg_digit(c.s);
        m_seen[idx] = 1'b1;
        if (d < 0) m_bad[idx] = 1'b1;
        else begin
          m_bad[idx] = 1'b0;
          m_sh[idx] = d;
        end
      end
      e_stale = ((edge_cnt - last_comp) >= T);

      check("frame_valid", frame_valid, e_fv);
      check("frame_err", frame_err, e_fe);
      check("changed", changed, e_ch);
      check("value", value, m_value);
      check("digits", digits, m_digits);
      check("stale", stale, e_stale);

      // scoreboard of completed frame values
      if (frame_valid) begin
        if (exp_q.size() == 0) check("frame_unexpected", 1, 0);
        else check("frame_value", value, exp_q.pop_front());
      end
      if (frame_valid) n_fv++;
      if (frame_err) n_fe++;
      if (changed) n_ch++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_raw(input logic [7:0] a, input logic [6:0] s, input int len);
    @(posedge clk);
    #1;
    an_in = a;
    sseg_in = s;
    if (len >= S + 1 && an_index(a) >= 0)
      cap_q.push_back('{at_edge: edge_cnt + 1 + S + 1, a: a, s: s});
    repeat (len - 1) @(posedge clk);
  endtask

  // Identical back-to-back dwells would merge on the bus, so split them with a dark gap
  task automatic drive_dwell(input logic [7:0] a, input logic [6:0] s, input int len);
    if ({a, s} == {an_in, sseg_in})
      apply_raw(8'hFF, s ^ 7'h01, 2);
    apply_raw(a, s, len);
  endtask

  task automatic scan(input int d3, input int d2, input int d1, input int d0, input int len);
    drive_dwell(8'b11111110, seg_tab[d0], len);
    drive_dwell(8'b11111101, seg_tab[d1], len);
    drive_dwell(8'b11111011, seg_tab[d2], len);
    drive_dwell(8'b11110111, seg_tab[d3], len);
  endtask

  task automatic pulse_reset(input int cycles);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  int b_fv, b_fe, b_ch;
  task automatic snap();
    b_fv = n_fv; b_fe = n_fe; b_ch = n_ch;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] a;
    logic [6:0] s;
    int len;
    an_in = 8'hFF;
    sseg_in = 7'h7F;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    drive_dwell(8'hFF, 7'h7F, 5);

    // clean frame 0123
    snap();
    scan(0, 1, 2, 3, 2 * S);
    check("clean_value", value, 123);
    check("clean_digits", digits, 16'h0123);
    check("clean_fv", n_fv - b_fv, 1);
    check("clean_changed", n_ch - b_ch, 1);

    // same frame again
    snap();
    scan(0, 1, 2, 3, 2 * S);
    check("repeat_value", value, 123);
    check("repeat_fv", n_fv - b_fv, 1);
    check("repeat_changed", n_ch - b_ch, 0);

    // short glitch on digit 0 is not captured
    snap();
    drive_dwell(8'b11111110, seg_tab[8], S - 2);
    drive_dwell(8'b11111110, seg_tab[5], 2 * S);
    drive_dwell(8'b11111101, seg_tab[2], 2 * S);
    drive_dwell(8'b11111011, seg_tab[1], 2 * S);
    drive_dwell(8'b11110111, seg_tab[0], 2 * S);
    check("glitch_value", value, 125);
    check("glitch_digits", digits, 16'h0125);
    check("glitch_fv", n_fv - b_fv, 1);

    // undecodable digit on an[1]
    snap();
    drive_dwell(8'b11111110, seg_tab[7], 2 * S);
    drive_dwell(8'b11111101, 7'b1111111, 2 * S);
    drive_dwell(8'b11111011, seg_tab[9], 2 * S);
    drive_dwell(8'b11110111, seg_tab[9], 2 * S);
    check("bad_fe", n_fe - b_fe, 1);
    check("bad_fv", n_fv - b_fv, 0);
    check("bad_value_hold", value, 125);
    snap();
    scan(9, 9, 9, 9, 2 * S);
    check("after_bad_value", value, 9999);
    check("after_bad_changed", n_ch - b_ch, 1);

    // invalid anodes never capture: three real digits alone cannot complete a frame
    snap();
    drive_dwell(8'b11111100, seg_tab[1], 3 * S);
    drive_dwell(8'b11101111, seg_tab[1], 3 * S);
    drive_dwell(8'b11111101, seg_tab[5], 2 * S);
    drive_dwell(8'b11111011, seg_tab[6], 2 * S);
    drive_dwell(8'b11110111, seg_tab[7], 2 * S);
    check("bad_anode_no_frame", n_fv - b_fv + n_fe - b_fe, 0);
    drive_dwell(8'b11111110, seg_tab[4], 2 * S);
    check("bad_anode_then_value", value, 7654);

    // random dwells around the settle threshold
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 99) < 85) begin
        case ($urandom_range(0, 3))
          0: a = 8'b11111110;
          1: a = 8'b11111101;
          2: a = 8'b11111011;
          default: a = 8'b11110111;
        endcase
      end else begin
        a = 8'($urandom);
      end
      if ($urandom_range(0, 99) < 90) s = seg_tab[$urandom_range(0, 9)];
      else s = 7'($urandom);
      case ($urandom_range(0, 3))
        0: len = S - 2 + $urandom_range(0, 5);
        1: len = 2 * S;
        2: len = $urandom_range(1, 4);
        default: len = S + 1;
      endcase
      drive_dwell(a, s, len);
    end

    // idle bus until the watchdog fires
    drive_dwell(8'hFF, 7'h7F, T + 20);
    check("timeout_stale", stale, 1);

    // reset after two digits discards the partial frame
    drive_dwell(8'b11111110, seg_tab[2], 2 * S);
    drive_dwell(8'b11111101, seg_tab[4], 2 * S);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("midreset_value", value, 0);
    check("midreset_stale", stale, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    snap();
    scan(0, 0, 4, 2, 2 * S);
    check("post_reset_value", value, 42);
    check("post_reset_digits", digits, 16'h0042);
    check("post_reset_stale", stale, 0);
    check("post_reset_fv", n_fv - b_fv, 1);
    check("post_reset_changed", n_ch - b_ch, 1);

    drive_dwell(8'hFF, 7'h7F, 8);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #5ms;
    errors++;
    checks++;
    $display("FAIL watchdog got=timeout expected=finish at edge %0d", edge_cnt);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
